// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared types, constants and slew-step helper for the servo scheduler
package servo_pkg;

  localparam int POS_W                 = 8;
  localparam int CENTER_POS            = 128;
  localparam int FRAME_CYCLES_24M_30MS = 720000;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } sched_state_t;

  // Magnitude of the move this frame: |diff| limited to step, so a move never overshoots.
  function automatic logic [POS_W-1:0] min_step(input logic signed [POS_W:0] diff,
                                                input logic [POS_W-1:0]       step);
    logic [POS_W:0] mag;
    mag = diff[POS_W] ? (POS_W+1)'(-diff) : (POS_W+1)'(diff);
    min_step = (mag > {1'b0, step}) ? step : mag[POS_W-1:0];
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// rtl/servo_frame_timer.sv - enable-gated frame counter producing tick and registered frame_start
module servo_frame_timer #(
  parameter int FRAME_CYCLES = 720000,
  parameter int CNT_W        = $clog2(FRAME_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick,
  output logic frame_start
);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == CNT_W'(FRAME_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick;
      if (tick) begin
        cnt <= '0;
      end else if (enable) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/servo_slew_scheduler.sv
// rtl/servo_slew_scheduler.sv - per-channel target store with once-per-frame rate-limited position scan
// Optional write clamping to [MIN_POS, MAX_POS] is enabled by defining SERVO_SOFTLIMIT_EN.
module servo_slew_scheduler
  import servo_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int FRAME_CYCLES = FRAME_CYCLES_24M_30MS,
  parameter int STEP         = 4,
  parameter int RESET_POS    = CENTER_POS,
  parameter int MIN_POS      = 16,
  parameter int MAX_POS      = 240,
  parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [CH_W-1:0]         wr_chan,
  input  logic [POS_W-1:0]        wr_pos,
  output logic [NUM_CH*POS_W-1:0] pos_flat,
  output logic                    frame_start,
  output logic                    busy,
  output logic [NUM_CH-1:0]       at_target,
  output logic                    limit_hit
);

`ifdef SERVO_SOFTLIMIT_EN
  localparam bit SOFTLIMIT = 1'b1;
`else
  localparam bit SOFTLIMIT = 1'b0;
`endif

  sched_state_t     state;
  logic [CH_W-1:0]  idx;
  logic [POS_W-1:0] target [NUM_CH];
  logic [POS_W-1:0] pos    [NUM_CH];
  logic             tick;
  logic             limit_hit_r;

  logic               wr_accept;
  logic               wr_in_range;
  logic               clamp_hit;
  logic [POS_W-1:0]   wr_pos_lim;
  logic [POS_W-1:0]   wr_pos_store;
  logic signed [POS_W:0] diff;
  logic [POS_W-1:0]   mag;
  logic [POS_W-1:0]   next_pos;

  servo_frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tick       (tick),
    .frame_start(frame_start)
  );

  always_comb begin
    wr_accept    = wr_valid && (state == IDLE);
    wr_in_range  = {1'b0, wr_chan} < (CH_W+1)'(NUM_CH);
    clamp_hit    = 1'b0;
    wr_pos_lim   = wr_pos;
    if (wr_pos < POS_W'(MIN_POS)) begin
      wr_pos_lim = POS_W'(MIN_POS);
      clamp_hit  = 1'b1;
    end else if (wr_pos > POS_W'(MAX_POS)) begin
      wr_pos_lim = POS_W'(MAX_POS);
      clamp_hit  = 1'b1;
    end
    wr_pos_store = SOFTLIMIT ? wr_pos_lim : wr_pos;

    // Signed 9-bit difference keeps the full -255..255 range without wrap.
    diff = $signed({1'b0, target[idx]}) - $signed({1'b0, pos[idx]});
    mag  = min_step(diff, POS_W'(STEP));
    if (diff > 9'sd0) begin
      next_pos = pos[idx] + mag;
    end else if (diff < 9'sd0) begin
      next_pos = pos[idx] - mag;
    end else begin
      next_pos = pos[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      limit_hit_r <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        target[i] <= POS_W'(RESET_POS);
        pos[i]    <= POS_W'(RESET_POS);
      end
    end else begin
      limit_hit_r <= SOFTLIMIT && wr_accept && wr_in_range && clamp_hit;
      if (wr_accept && wr_in_range) begin
        target[wr_chan] <= wr_pos_store;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            state <= SCAN;
            idx   <= '0;
          end
        end
        SCAN: begin
          if (enable) begin
            pos[idx] <= next_pos;
            if (idx == CH_W'(NUM_CH - 1)) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + CH_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_ready  = (state == IDLE);
  assign busy      = (state == SCAN);
  assign limit_hit = limit_hit_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_out
    assign pos_flat[i*POS_W +: POS_W] = pos[i];
    assign at_target[i]               = (pos[i] == target[i]);
  end

endmodule
